// File: rtl/snitch_hwloop_pkg.sv
// Shared types for the Snitch hardware-loop controller.
//   hwloop_ctrl_state_e : controller sequencing states
//   hwloop_cfg_t        : captured loop-setup request (start, end, count)
package snitch_hwloop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROG  = 2'd1,
        ARM   = 2'd2,
        FLUSH = 2'd3
    } hwloop_ctrl_state_e;

    typedef struct packed {
        logic [31:0] start;
        logic [31:0] end_addr;
        logic [31:0] count;
    } hwloop_cfg_t;

endpackage

// File: rtl/snitch_hwloop_shadow.sv
// Shadow end-address / remaining-count table for the hardware-loop sets.
//   clk_i, rst_ni                 : clock, async active-low reset
//   clear_i                       : zero every entry
//   alloc_i/alloc_idx_i/
//   alloc_end_i/alloc_cnt_i       : load an entry when a loop is allocated
//   top_valid_i/top_idx_i         : innermost active entry (stack top)
//   retire_valid_i/retire_pc_i    : retired instruction
//   track_en_i                    : enable the retire comparison
//   match_o                       : retired PC is the last body instruction of top
//   last_o                        : top entry has at most one iteration left
//   dec_i                         : decrement the top entry's count
//   pop_i                         : top loop exits, its entry is cleared
import snitch_hwloop_pkg::*;

module snitch_hwloop_shadow #(
    parameter int unsigned N_HW_LOOPS = 2,
    parameter int unsigned N_REG_BITS = (N_HW_LOOPS > 1) ? $clog2(N_HW_LOOPS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  alloc_i,
    input  logic [N_REG_BITS-1:0] alloc_idx_i,
    input  logic [31:0]           alloc_end_i,
    input  logic [31:0]           alloc_cnt_i,
    input  logic                  top_valid_i,
    input  logic [N_REG_BITS-1:0] top_idx_i,
    input  logic                  retire_valid_i,
    input  logic [31:0]           retire_pc_i,
    input  logic                  track_en_i,
    output logic                  match_o,
    output logic                  last_o,
    input  logic                  dec_i,
    input  logic                  pop_i
);

    logic [31:0] end_q [N_HW_LOOPS];
    logic [31:0] end_d [N_HW_LOOPS];
    logic [31:0] cnt_q [N_HW_LOOPS];
    logic [31:0] cnt_d [N_HW_LOOPS];

    logic [31:0] top_end;
    logic [31:0] top_cnt;

    assign top_end = end_q[top_idx_i];
    assign top_cnt = cnt_q[top_idx_i];

    // end is the address after the last body instruction
    assign match_o = track_en_i && top_valid_i && retire_valid_i &&
                     ((retire_pc_i + 32'd4) == top_end);
    assign last_o  = (top_cnt <= 32'd1);

    always_comb begin
        end_d = end_q;
        cnt_d = cnt_q;
        if (dec_i) begin
            cnt_d[top_idx_i] = top_cnt - 32'd1;
        end
        if (pop_i) begin
            end_d[top_idx_i] = '0;
            cnt_d[top_idx_i] = '0;
        end
        // Allocation after pop: a same-cycle push reuses the freed index.
        if (alloc_i) begin
            end_d[alloc_idx_i] = alloc_end_i;
            cnt_d[alloc_idx_i] = alloc_cnt_i;
        end
        if (clear_i) begin
            for (int unsigned i = 0; i < N_HW_LOOPS; i++) begin
                end_d[i] = '0;
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_HW_LOOPS; i++) begin
                end_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            end_q <= end_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snitch_hwloop_ctrl.sv
// Hardware-loop setup sequencer and loop-set allocator.
// Loops are kept as a nesting stack: the innermost loop occupies the lowest
// active index, so with depth d the active sets are N-d .. N-1.
//   clk_i, rst_ni                        : clock, async active-low reset
//   req_valid_i/req_ready_o              : loop-setup handshake
//   req_start_i/req_end_i/req_count_i    : loop start, end (after last instr), count
//   retire_valid_i/retire_pc_i           : retired instruction stream
//   flush_i                              : discard all active loops
//   hwloop_regid_o                       : register set being written
//   hwloop_start_o/_end_o/_cnt_o         : write data
//   hwloop_we_start_o/_we_end_o/_we_count_o : write enables
//   depth_o                              : number of active loops
//   busy_o                               : controller not in IDLE
import snitch_hwloop_pkg::*;

module snitch_hwloop_ctrl #(
  parameter int unsigned N_HW_LOOPS = 2,
  parameter int unsigned N_REG_BITS = (N_HW_LOOPS > 1) ? $clog2(N_HW_LOOPS) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [31:0]                       req_start_i,
  input  logic [31:0]                       req_end_i,
  input  logic [31:0]                       req_count_i,
  input  logic                              retire_valid_i,
  input  logic [31:0]                       retire_pc_i,
  input  logic                              flush_i,
  output logic [N_REG_BITS-1:0]             hwloop_regid_o,
  output logic [31:0]                       hwloop_start_o,
  output logic [31:0]                       hwloop_end_o,
  output logic [31:0]                       hwloop_cnt_o,
  output logic                              hwloop_we_start_o,
  output logic                              hwloop_we_end_o,
  output logic                              hwloop_we_count_o,
  output logic [$clog2(N_HW_LOOPS+1)-1:0]   depth_o,
  output logic                              busy_o
);

  localparam int unsigned DEPTH_BITS = $clog2(N_HW_LOOPS + 1);
  localparam logic [N_REG_BITS-1:0] LAST_PTR = N_REG_BITS'(N_HW_LOOPS - 1);
  localparam logic [DEPTH_BITS-1:0] FULL_DEPTH = DEPTH_BITS'(N_HW_LOOPS);

  hwloop_ctrl_state_e state_q, state_d;
  logic [DEPTH_BITS-1:0] depth_q, depth_d;
  logic [N_REG_BITS-1:0] ptr_q, ptr_d;
  logic [N_REG_BITS-1:0] regid_q, regid_d;
  hwloop_cfg_t           wdata_q, wdata_d;
  logic                  we_start_q, we_start_d;
  logic                  we_end_q, we_end_d;
  logic                  we_count_q, we_count_d;

  hwloop_cfg_t           req_cfg;
  logic                  full;
  logic                  req_hs;
  logic [N_REG_BITS-1:0] top_idx;
  logic [N_REG_BITS-1:0] alloc_idx;
  logic                  track_en;
  logic                  shadow_match;
  logic                  shadow_last;
  logic                  shadow_dec;
  logic                  shadow_pop;
  logic                  shadow_clear;

  assign req_cfg = '{start: req_start_i, end_addr: req_end_i, count: req_count_i};
  assign full    = (depth_q == FULL_DEPTH);

  // Tracking is suspended while a flush is requested or running; the
  // flush discards every loop anyway.
  assign track_en   = (state_q != FLUSH) && !flush_i;
  assign shadow_dec = shadow_match && !shadow_last;
  assign shadow_pop = shadow_match && shadow_last;

  // A loop exiting this cycle frees its set, so a full stack can still
  // accept a request that takes over the freed index.
  assign req_ready_o = (state_q == IDLE) && !flush_i && (!full || shadow_pop);
  assign req_hs      = req_valid_i && req_ready_o;

  always_comb begin
    top_idx = '0;
    if (depth_q != '0) begin
      top_idx = N_REG_BITS'(N_HW_LOOPS - 32'(depth_q));
    end
    alloc_idx = shadow_pop ? top_idx
                           : N_REG_BITS'(N_HW_LOOPS - 32'd1 - 32'(depth_q));
  end

  snitch_hwloop_shadow #(
    .N_HW_LOOPS (N_HW_LOOPS),
    .N_REG_BITS (N_REG_BITS)
  ) i_shadow (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (shadow_clear),
    .alloc_i        (req_hs),
    .alloc_idx_i    (alloc_idx),
    .alloc_end_i    (req_end_i),
    .alloc_cnt_i    (req_count_i),
    .top_valid_i    (depth_q != '0),
    .top_idx_i      (top_idx),
    .retire_valid_i (retire_valid_i),
    .retire_pc_i    (retire_pc_i),
    .track_en_i     (track_en),
    .match_o        (shadow_match),
    .last_o         (shadow_last),
    .dec_i          (shadow_dec),
    .pop_i          (shadow_pop)
  );

  // Outputs are computed for the next state so they are flop-driven and
  // line up with PROG / FLUSH cycles.
  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    ptr_d        = ptr_q;
    regid_d      = regid_q;
    wdata_d      = wdata_q;
    we_start_d   = 1'b0;
    we_end_d     = 1'b0;
    we_count_d   = 1'b0;
    shadow_clear = 1'b0;

    if (req_hs && !shadow_pop) begin
      depth_d = depth_q + DEPTH_BITS'(1);
    end else if (!req_hs && shadow_pop) begin
      depth_d = depth_q - DEPTH_BITS'(1);
    end

    case (state_q)
      IDLE: begin
        if (req_hs) begin
          state_d    = PROG;
          regid_d    = alloc_idx;
          wdata_d    = req_cfg;
          we_start_d = 1'b1;
          we_end_d   = 1'b1;
          we_count_d = 1'b1;
        end
      end
      PROG:  state_d = ARM;
      ARM:   state_d = IDLE;
      FLUSH: begin
        if (ptr_q == LAST_PTR) begin
          state_d      = IDLE;
          depth_d      = '0;
          shadow_clear = 1'b1;
        end else begin
          ptr_d         = ptr_q + N_REG_BITS'(1);
          regid_d       = ptr_q + N_REG_BITS'(1);
          wdata_d.count = '0;
          we_count_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d       = FLUSH;
      depth_d       = depth_q;
      ptr_d         = '0;
      regid_d       = '0;
      wdata_d.count = '0;
      we_start_d    = 1'b0;
      we_end_d      = 1'b0;
      we_count_d    = 1'b1;
      shadow_clear  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      depth_q    <= '0;
      ptr_q      <= '0;
      regid_q    <= '0;
      wdata_q    <= '0;
      we_start_q <= 1'b0;
      we_end_q   <= 1'b0;
      we_count_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      ptr_q      <= ptr_d;
      regid_q    <= regid_d;
      wdata_q    <= wdata_d;
      we_start_q <= we_start_d;
      we_end_q   <= we_end_d;
      we_count_q <= we_count_d;
    end
  end

  assign hwloop_regid_o    = regid_q;
  assign hwloop_start_o    = wdata_q.start;
  assign hwloop_end_o      = wdata_q.end_addr;
  assign hwloop_cnt_o      = wdata_q.count;
  assign hwloop_we_start_o = we_start_q;
  assign hwloop_we_end_o   = we_end_q;
  assign hwloop_we_count_o = we_count_q;
  assign depth_o           = depth_q;
  assign busy_o            = (state_q != IDLE);

  a_single_burst: assert property (@(posedge clk_i) disable iff (!rst_ni)
    we_start_q |=> !we_start_q);
  a_depth_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    depth_q <= FULL_DEPTH);
  a_no_full_hs: assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_hs |-> (!full || shadow_pop));

endmodule
